// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the in-place radix-2 FFT sequencer.
package fft_pkg;

  localparam int N             = 16;
  localparam int LOG2N         = 4;
  localparam int ADDR_WIDTH    = LOG2N;
  localparam int TW_ADDR_WIDTH = LOG2N - 1;
  localparam int RD_LATENCY    = 1;
  localparam int BF_LATENCY    = 2;
  localparam int WB_DELAY      = RD_LATENCY + BF_LATENCY;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_FLUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Maps (stage, butterfly index) to the two data-RAM operand addresses and the
// twiddle-ROM address for a radix-2 DIT butterfly on bit-reversed input.
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [LOG2N-1:0]         stage,
  input  logic [LOG2N-2:0]         bf_idx,
  output logic [ADDR_WIDTH-1:0]    addr0,
  output logic [ADDR_WIDTH-1:0]    addr1,
  output logic [TW_ADDR_WIDTH-1:0] tw_addr
);

  localparam logic [LOG2N-1:0] TW_SH_MAX = LOG2N'(LOG2N - 1);

  logic [ADDR_WIDTH-1:0] b_ext;
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] pos;
  logic [ADDR_WIDTH-1:0] grp;
  logic [LOG2N-1:0]      tw_sh;

  // Split the butterfly index into group and in-group position for this stage.
  always_comb begin
    b_ext   = ADDR_WIDTH'(bf_idx);
    span    = ADDR_WIDTH'(1) << stage;
    pos     = b_ext & (span - 1'b1);
    grp     = b_ext >> stage;
    addr0   = (grp << (stage + 1'b1)) | pos;
    addr1   = addr0 + span;
    tw_sh   = TW_SH_MAX - stage;
    tw_addr = TW_ADDR_WIDTH'(pos) << tw_sh;
  end

endmodule

// File: rtl/fft_bf_scheduler.sv
// Sequencer for the shared radix-2 butterfly: walks every stage and butterfly,
// issues RAM reads and twiddle addresses, and replays the read addresses as
// write-back addresses after the read + butterfly latency.
module fft_bf_scheduler
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDR_WIDTH-1:0]    rd_addr0,
  output logic [ADDR_WIDTH-1:0]    rd_addr1,
  output logic [TW_ADDR_WIDTH-1:0] tw_addr,
  output logic                     bf_rst,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr0,
  output logic [ADDR_WIDTH-1:0]    wr_addr1,
  output logic [LOG2N-1:0]         stage
);

  localparam int               BF_W       = LOG2N - 1;
  localparam logic [BF_W-1:0]  LAST_BF    = BF_W'(N / 2 - 1);
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);

  state_t                state;
  logic [BF_W-1:0]       bf_idx;
  logic                  gap_cnt;
  logic [WB_DELAY-1:0]   vld_pipe;
  logic [ADDR_WIDTH-1:0] a0_pipe [WB_DELAY];
  logic [ADDR_WIDTH-1:0] a1_pipe [WB_DELAY];

  logic [LOG2N-1:0]         gen_stage;
  logic [BF_W-1:0]          gen_bf;
  logic [ADDR_WIDTH-1:0]    gen_a0;
  logic [ADDR_WIDTH-1:0]    gen_a1;
  logic [TW_ADDR_WIDTH-1:0] gen_tw;

  // Write-back strobe and addresses are the tail of the read delay line.
  assign wr_en    = vld_pipe[WB_DELAY-1];
  assign wr_addr0 = a0_pipe[WB_DELAY-1];
  assign wr_addr1 = a1_pipe[WB_DELAY-1];

  // Select which butterfly the next issue will address (first of next stage in GAP).
  always_comb begin
    gen_stage = '0;
    gen_bf    = '0;
    if (state == ST_RUN) begin
      gen_stage = stage;
      gen_bf    = bf_idx;
    end else if (state == ST_GAP) begin
      gen_stage = stage + 1'b1;
    end
  end

  fft_addr_gen u_addr_gen (
    .stage   (gen_stage),
    .bf_idx  (gen_bf),
    .addr0   (gen_a0),
    .addr1   (gen_a1),
    .tw_addr (gen_tw)
  );

  // Control FSM, issue counter and write-back delay line.
  // bf_idx always names the next butterfly to issue; it wraps to 0 once the
  // last butterfly of a stage has gone out, which is what ends the stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
      tw_addr  <= '0;
      bf_rst   <= 1'b1;
      stage    <= '0;
      bf_idx   <= '0;
      gap_cnt  <= 1'b0;
      vld_pipe <= '0;
      for (int unsigned i = 0; i < WB_DELAY; i++) begin
        a0_pipe[i] <= '0;
        a1_pipe[i] <= '0;
      end
    end else begin
      vld_pipe   <= {vld_pipe[WB_DELAY-2:0], rd_en};
      a0_pipe[0] <= rd_addr0;
      a1_pipe[0] <= rd_addr1;
      for (int unsigned i = 1; i < WB_DELAY; i++) begin
        a0_pipe[i] <= a0_pipe[i-1];
        a1_pipe[i] <= a1_pipe[i-1];
      end

      done  <= 1'b0;
      rd_en <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          busy   <= 1'b0;
          bf_rst <= 1'b1;
          if (start) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            rd_addr0 <= gen_a0;
            rd_addr1 <= gen_a1;
            tw_addr  <= gen_tw;
            stage    <= '0;
            bf_idx   <= BF_W'(1);
          end
        end

        ST_RUN: begin
          bf_rst <= 1'b0;
          if (rd_en) begin
            if (bf_idx == '0 && stage == LAST_STAGE) begin
              state <= ST_FLUSH;
            end
          end else if (bf_idx == '0) begin
            state   <= ST_GAP;
            gap_cnt <= 1'b0;
          end else begin
            rd_en    <= 1'b1;
            rd_addr0 <= gen_a0;
            rd_addr1 <= gen_a1;
            tw_addr  <= gen_tw;
            bf_idx   <= (bf_idx == LAST_BF) ? '0 : bf_idx + 1'b1;
          end
        end

        ST_GAP: begin
          if (!gap_cnt) begin
            gap_cnt <= 1'b1;
          end else begin
            state    <= ST_RUN;
            rd_en    <= 1'b1;
            rd_addr0 <= gen_a0;
            rd_addr1 <= gen_a1;
            tw_addr  <= gen_tw;
            stage    <= stage + 1'b1;
            bf_idx   <= BF_W'(1);
          end
        end

        ST_FLUSH: begin
          // Leave once the only write still in flight is the one on the bus now.
          if (vld_pipe[WB_DELAY-2:0] == '0) begin
            state  <= ST_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            bf_rst <= 1'b1;
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          bf_rst <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bf_scheduler.sv
// Self-checking bench for fft_bf_scheduler: cycle-accurate expectations built
// from the butterfly enumeration, plus a RAM/butterfly model checked against a
// direct DFT.
module tb_fft_bf_scheduler;

  localparam int  NPT     = 16;
  localparam int  LG      = 4;
  localparam int  STG_LEN = NPT + 2;
  localparam int  RUN_LEN = LG * STG_LEN;
  localparam int  TLEN    = RUN_LEN + 2;
  localparam real PI      = 3.14159265358979323846;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, rd_en, bf_rst, wr_en;
  logic [3:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1, stage;
  logic [2:0] tw_addr;

  int checks = 0;
  int errors = 0;

  bit exp_rd [TLEN + 4];
  bit exp_wr [TLEN + 4];
  int exp_a0 [TLEN + 4];
  int exp_a1 [TLEN + 4];
  int exp_tw [TLEN + 4];
  int exp_w0 [TLEN + 4];
  int exp_w1 [TLEN + 4];

  real mem_re [NPT];
  real mem_im [NPT];
  real ref_re [NPT];
  real ref_im [NPT];

  typedef struct {
    int  tw;
    real ar;
    real ai;
    real br;
    real bi;
  } rd_t;
  rd_t rq [$];

  always #5 clk = ~clk;

  fft_bf_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .tw_addr  (tw_addr),
    .bf_rst   (bf_rst),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1),
    .stage    (stage)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    for (int i = 0; i < LG; i++) if (((v >> i) & 1) != 0) r |= 1 << (LG - 1 - i);
    return r;
  endfunction

  // Enumerate every butterfly as (group, position) pairs and place its issue
  // and write-back on the cycle timeline.
  task automatic build_model();
    int span, b, t, a0;
    for (int i = 0; i < TLEN + 4; i++) begin
      exp_rd[i] = 0; exp_wr[i] = 0;
      exp_a0[i] = 0; exp_a1[i] = 0; exp_tw[i] = 0; exp_w0[i] = 0; exp_w1[i] = 0;
    end
    for (int s = 0; s < LG; s++) begin
      span = 1 << s;
      b = 0;
      for (int g = 0; g < NPT / (2 * span); g++) begin
        for (int p = 0; p < span; p++) begin
          t  = s * STG_LEN + 2 * b;
          a0 = g * 2 * span + p;
          exp_rd[t] = 1;
          exp_a0[t] = a0;
          exp_a1[t] = a0 + span;
          exp_tw[t] = p * (NPT / (2 * span));
          exp_wr[t + 3] = 1;
          exp_w0[t + 3] = a0;
          exp_w1[t + 3] = a0 + span;
          b++;
        end
      end
    end
  endtask

  task automatic load_data(input bit impulse);
    for (int n = 0; n < NPT; n++) begin
      if (impulse) begin
        mem_re[bitrev(n)] = (n == 0) ? 16384.0 : 0.0;
        mem_im[bitrev(n)] = 0.0;
      end else begin
        mem_re[bitrev(n)] = real'($urandom_range(4000)) - 2000.0;
        mem_im[bitrev(n)] = real'($urandom_range(4000)) - 2000.0;
      end
    end
  endtask

  // Direct DFT of whatever the RAM holds, read in natural order.
  task automatic compute_ref();
    real xr, xi, c, sn;
    for (int k = 0; k < NPT; k++) begin
      ref_re[k] = 0.0;
      ref_im[k] = 0.0;
      for (int n = 0; n < NPT; n++) begin
        xr = mem_re[bitrev(n)];
        xi = mem_im[bitrev(n)];
        c  = $cos(2.0 * PI * real'(n * k) / real'(NPT));
        sn = $sin(2.0 * PI * real'(n * k) / real'(NPT));
        ref_re[k] += xr * c + xi * sn;
        ref_im[k] += xi * c - xr * sn;
      end
    end
  endtask

  // One full run, cycle by cycle from R0 through the IDLE cycle after DONE.
  // mode 0: start low; 1: random start pulses while busy; 2: start held high.
  task automatic run_trace(input bit do_start, input int mode);
    int  n_rd, n_wr, n_done;
    rd_t e;
    real wre, wim, pr, pim, d;
    bit  exp_busy, exp_done, exp_bfr;
    n_rd = 0; n_wr = 0; n_done = 0;
    rq.delete();
    compute_ref();
    if (do_start) begin
      start = 1'b1;
      step();
    end
    for (int t = 0; t < TLEN; t++) begin
      if (wr_en === 1'b1) begin
        n_wr++;
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_pending t=%0d got write with no outstanding read, required an earlier issue", t);
        end else begin
          e   = rq.pop_front();
          wre = $cos(2.0 * PI * real'(e.tw) / real'(NPT));
          wim = -$sin(2.0 * PI * real'(e.tw) / real'(NPT));
          pr  = e.br * wre - e.bi * wim;
          pim = e.br * wim + e.bi * wre;
          mem_re[wr_addr0] = e.ar + pr;
          mem_im[wr_addr0] = e.ai + pim;
          mem_re[wr_addr1] = e.ar - pr;
          mem_im[wr_addr1] = e.ai - pim;
        end
      end
      if (rd_en === 1'b1) begin
        n_rd++;
        e.tw = int'(tw_addr);
        e.ar = mem_re[rd_addr0]; e.ai = mem_im[rd_addr0];
        e.br = mem_re[rd_addr1]; e.bi = mem_im[rd_addr1];
        rq.push_back(e);
      end
      if (done === 1'b1) n_done++;

      exp_busy = (t < RUN_LEN);
      exp_done = (t == RUN_LEN);
      exp_bfr  = (t == 0) || (t >= RUN_LEN);

      checks++;
      if (rd_en !== exp_rd[t]) begin
        errors++; $display("FAIL rd_en t=%0d got %0b want %0b", t, rd_en, exp_rd[t]);
      end
      checks++;
      if (wr_en !== exp_wr[t]) begin
        errors++; $display("FAIL wr_en t=%0d got %0b want %0b", t, wr_en, exp_wr[t]);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL busy t=%0d got %0b want %0b", t, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        errors++; $display("FAIL done t=%0d got %0b want %0b", t, done, exp_done);
      end
      checks++;
      if (bf_rst !== exp_bfr) begin
        errors++; $display("FAIL bf_rst t=%0d got %0b want %0b", t, bf_rst, exp_bfr);
      end
      if (t < RUN_LEN) begin
        checks++;
        if (int'(stage) != t / STG_LEN) begin
          errors++; $display("FAIL stage t=%0d got %0d want %0d", t, stage, t / STG_LEN);
        end
      end
      if (exp_rd[t]) begin
        checks++;
        if (int'(rd_addr0) != exp_a0[t] || int'(rd_addr1) != exp_a1[t] || int'(tw_addr) != exp_tw[t]) begin
          errors++;
          $display("FAIL rd_addr t=%0d got (%0d,%0d,tw %0d) want (%0d,%0d,tw %0d)",
                   t, rd_addr0, rd_addr1, tw_addr, exp_a0[t], exp_a1[t], exp_tw[t]);
        end
      end
      if (exp_wr[t]) begin
        checks++;
        if (int'(wr_addr0) != exp_w0[t] || int'(wr_addr1) != exp_w1[t]) begin
          errors++;
          $display("FAIL wr_addr t=%0d got (%0d,%0d) want (%0d,%0d)", t, wr_addr0, wr_addr1, exp_w0[t], exp_w1[t]);
        end
      end
      if (t == 0 || t == STG_LEN + 6 || t == 3 * STG_LEN + 14) begin
        checks++;
        if ((t == 0 && (rd_addr0 !== 4'd0 || rd_addr1 !== 4'd1 || tw_addr !== 3'd0)) ||
            (t == STG_LEN + 6 && (rd_addr0 !== 4'd5 || rd_addr1 !== 4'd7 || tw_addr !== 3'd4)) ||
            (t == 3 * STG_LEN + 14 && (rd_addr0 !== 4'd7 || rd_addr1 !== 4'd15 || tw_addr !== 3'd7))) begin
          errors++;
          $display("FAIL addr_point t=%0d got (%0d,%0d,tw %0d)", t, rd_addr0, rd_addr1, tw_addr);
        end
      end

      case (mode)
        1:       start = (t <= RUN_LEN) ? 1'($urandom_range(1)) : 1'b0;
        2:       start = 1'b1;
        default: start = 1'b0;
      endcase
      step();
    end

    checks++;
    if (n_rd != NPT / 2 * LG) begin
      errors++; $display("FAIL rd_count got %0d want %0d", n_rd, NPT / 2 * LG);
    end
    checks++;
    if (n_wr != NPT / 2 * LG) begin
      errors++; $display("FAIL wr_count got %0d want %0d", n_wr, NPT / 2 * LG);
    end
    checks++;
    if (n_done != 1) begin
      errors++; $display("FAIL done_count got %0d want 1", n_done);
    end
    for (int k = 0; k < NPT; k++) begin
      checks++;
      d = (mem_re[k] - ref_re[k]) + (mem_im[k] - ref_im[k]);
      if ((mem_re[k] - ref_re[k]) > 2.0 || (mem_re[k] - ref_re[k]) < -2.0 ||
          (mem_im[k] - ref_im[k]) > 2.0 || (mem_im[k] - ref_im[k]) < -2.0) begin
        errors++;
        $display("FAIL fft_bin k=%0d got (%0f,%0f) want (%0f,%0f) sumdiff %0f",
                 k, mem_re[k], mem_im[k], ref_re[k], ref_im[k], d);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0 || bf_rst !== 1'b1 ||
        stage !== 4'd0 || rd_addr0 !== 4'd0 || rd_addr1 !== 4'd0 || tw_addr !== 3'd0 ||
        wr_addr0 !== 4'd0 || wr_addr1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_values got busy %0b done %0b rd %0b wr %0b bf_rst %0b stage %0d, want 0 0 0 0 1 0",
               busy, done, rd_en, wr_en, bf_rst, stage);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0 || bf_rst !== 1'b1) begin
        errors++;
        $display("FAIL idle cyc=%0d got busy %0b done %0b rd %0b wr %0b bf_rst %0b want 0 0 0 0 1",
                 i, busy, done, rd_en, wr_en, bf_rst);
      end
    end
  endtask

  task automatic test_impulse();
    load_data(1'b1);
    run_trace(1'b1, 0);
    for (int k = 0; k < NPT; k++) begin
      checks++;
      if (mem_re[k] > 16386.0 || mem_re[k] < 16382.0 || mem_im[k] > 2.0 || mem_im[k] < -2.0) begin
        errors++;
        $display("FAIL impulse_bin k=%0d got (%0f,%0f) want (16384,0)", k, mem_re[k], mem_im[k]);
      end
    end
  endtask

  task automatic test_random_data();
    for (int r = 0; r < 2; r++) begin
      load_data(1'b0);
      run_trace(1'b1, 0);
    end
  endtask

  task automatic test_start_ignored();
    load_data(1'b0);
    run_trace(1'b1, 1);
  endtask

  task automatic test_back_to_back();
    load_data(1'b0);
    run_trace(1'b1, 2);
    run_trace(1'b0, 0);
  endtask

  task automatic test_abort();
    load_data(1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 30; i++) step();
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0 || bf_rst !== 1'b1 ||
        stage !== 4'd0 || rd_addr0 !== 4'd0 || rd_addr1 !== 4'd0 || tw_addr !== 3'd0 ||
        wr_addr0 !== 4'd0 || wr_addr1 !== 4'd0) begin
      errors++;
      $display("FAIL abort_values got busy %0b done %0b rd %0b wr %0b bf_rst %0b stage %0d, want 0 0 0 0 1 0",
               busy, done, rd_en, wr_en, bf_rst, stage);
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet cyc=%0d got wr %0b rd %0b busy %0b done %0b want 0 0 0 0",
                 i, wr_en, rd_en, busy, done);
      end
    end
    run_trace(1'b1, 0);
  endtask

  initial begin
    build_model();
    test_reset();
    test_impulse();
    test_random_data();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
